mem_access_stage: RTL and testbench

//  Pipeline stage directly downstream of the ALU. Takes one ALU result per accepted op. Ld/st ops become a

---
 rtl/proc_pkg.sv | 33 +++
 rtl/mem_wait_timer.sv | 39 +++
 rtl/mem_access_stage.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: ALU op bit indices,
// datapath defaults and memory-stage FSM states.
package proc_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 16;
  localparam int RA_W_DEF    = 3;
  localparam int TIMEOUT_DEF = 64;
  localparam int ALU_W       = 12;

  localparam int ALU_ISADD = 0;
  localparam int ALU_ISLD  = 1;
  localparam int ALU_ISST  = 2;
  localparam int ALU_ISSUB = 3;
  localparam int ALU_ISMUL = 4;
  localparam int ALU_ISCMP = 5;
  localparam int ALU_ISAND = 6;
  localparam int ALU_ISOR  = 7;
  localparam int ALU_ISXOR = 8;
  localparam int ALU_ISNOT = 9;
  localparam int ALU_ISLSL = 10;
  localparam int ALU_ISLSR = 11;

  localparam logic [2:0] FLAGS_REG = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_REQ  = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_WB_HOLD  = 2'd3
  } mas_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for a memory response;
// expired_o flags the last allowed wait cycle.
module mem_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // next count: clear wins, saturate at LAST
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: turns ld/st ALU results
// into memory requests and emits one writeback per op.
module mem_access_stage
  import proc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int RA_W    = RA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ALU_W-1:0]  in_alusignals,
  input  logic [DATA_W-1:0] in_aluresult,
  input  logic [DATA_W-1:0] in_stdata,
  input  logic [RA_W-1:0]   in_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_we,
  output logic [RA_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  mas_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [RA_W-1:0]   rd_q, rd_d;
  logic              we_q, we_d;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_we_q, wb_we_d;
  logic [RA_W-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              err_q, err_d;

  logic op_mem, op_st, op_we;
  logic accept, tmr_clear, tmr_en, tmr_expired;

  // WB_HOLD behaves like IDLE for accepts so ALU ops stream
  assign in_ready = ((state_q == S_IDLE) || (state_q == S_WB_HOLD))
                    && (!wb_valid_q || wb_ready);
  assign accept   = in_valid && in_ready;

  assign tmr_clear = (state_q == S_MEM_REQ) && mem_req_ready;
  assign tmr_en    = (state_q == S_MEM_WAIT);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (tmr_clear),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // op class: ld beats st, memory beats everything else
  always_comb begin
    op_mem = 1'b0;
    op_st  = 1'b0;
    op_we  = 1'b0;
    priority case (1'b1)
      in_alusignals[ALU_ISLD]: op_mem = 1'b1;
      in_alusignals[ALU_ISST]: begin
        op_mem = 1'b1;
        op_st  = 1'b1;
      end
      in_alusignals[ALU_ISCMP],
      ~|in_alusignals:         op_we = 1'b0;
      default:                 op_we = 1'b1;
    endcase
  end

  // next state, capture and writeback record
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    we_d       = we_q;
    wb_valid_d = wb_valid_q;
    wb_we_d    = wb_we_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE, S_WB_HOLD: begin
        if (wb_valid_q && wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
        if (accept) begin
          if (op_mem) begin
            addr_d  = in_aluresult[ADDR_W-1:0];
            wdata_d = in_stdata;
            rd_d    = in_rd;
            we_d    = op_st;
            state_d = S_MEM_REQ;
          end else begin
            wb_valid_d = 1'b1;
            wb_we_d    = op_we;
            wb_rd_d    = in_rd;
            wb_data_d  = in_aluresult;
            state_d    = S_WB_HOLD;
          end
        end
      end
      S_MEM_REQ: begin
        if (mem_req_ready) begin
          state_d = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (mem_rsp_valid) begin
          wb_valid_d = 1'b1;
          wb_we_d    = !we_q;
          wb_rd_d    = rd_q;
          wb_data_d  = we_q ? '0 : mem_rsp_rdata;
          state_d    = S_WB_HOLD;
        end else if (tmr_expired) begin
          err_d      = 1'b1;
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b0;
          wb_rd_d    = rd_q;
          wb_data_d  = '0;
          state_d    = S_WB_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  assign mem_req_valid = (state_q == S_MEM_REQ);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;

  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_we_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign mem_err  = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU passthrough,
// ld/st, backpressure, timeout and async reset.
module tb_mem_access_stage;
  import proc_pkg::*;

  localparam int TO = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_alusignals;
  logic [15:0] in_aluresult;
  logic [15:0] in_stdata;
  logic [2:0]  in_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [15:0] mem_req_addr;
  logic [15:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [15:0] mem_rsp_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .RA_W    (3),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alusignals (in_alusignals),
    .in_aluresult  (in_aluresult),
    .in_stdata     (in_stdata),
    .in_rd         (in_rd),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .mem_err       (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag,
                        input logic v, input logic we,
                        input logic [2:0] rd,
                        input logic [15:0] d);
    chk({tag, ".valid"}, {31'd0, wb_valid}, {31'd0, v});
    chk({tag, ".we"},    {31'd0, wb_we},    {31'd0, we});
    chk({tag, ".rd"},    {29'd0, wb_rd},    {29'd0, rd});
    chk({tag, ".data"},  {16'd0, wb_data},  {16'd0, d});
  endtask

  localparam logic [11:0] OP_ADD = 12'h001;
  localparam logic [11:0] OP_LD  = 12'h002;
  localparam logic [11:0] OP_ST  = 12'h004;
  localparam logic [11:0] OP_CMP = 12'h020;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_alusignals = '0;
    in_aluresult = '0;
    in_stdata = '0;
    in_rd = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    wb_ready = 1'b1;
    tick();
    tick();
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst.req_we", {31'd0, mem_req_we}, 32'd0);
    chk("rst.mem_err", {31'd0, mem_err}, 32'd0);
    chk_wb("rst", 1'b0, 1'b0, 3'd0, 16'h0000);
    rst_n = 1'b1;
    tick();

    // 1: add, then back-to-back add
    in_valid = 1'b1;
    in_alusignals = OP_ADD;
    in_aluresult = 16'h0012;
    in_rd = 3'd3;
    #1;
    chk("add.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk_wb("add1", 1'b1, 1'b1, 3'd3, 16'h0012);
    in_aluresult = 16'h0034;
    in_rd = 3'd4;
    #1;
    chk("add.b2b_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk_wb("add2", 1'b1, 1'b1, 3'd4, 16'h0034);
    in_valid = 1'b0;
    tick();
    chk("add.drain", {31'd0, wb_valid}, 32'd0);

    // 2: load BEEF
    in_valid = 1'b1;
    in_alusignals = OP_LD;
    in_aluresult = 16'h0040;
    in_rd = 3'd2;
    mem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_aluresult = 16'hFFFF;
    #1;
    chk("ld.req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("ld.req_we", {31'd0, mem_req_we}, 32'd0);
    chk("ld.req_addr", {16'd0, mem_req_addr}, 32'h0040);
    chk("ld.in_ready0", {31'd0, in_ready}, 32'd0);
    tick();
    mem_req_ready = 1'b0;
    #1;
    chk("ld.wait_req", {31'd0, mem_req_valid}, 32'd0);
    chk("ld.in_ready1", {31'd0, in_ready}, 32'd0);
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 16'hBEEF;
    #1;
    chk("ld.in_ready2", {31'd0, in_ready}, 32'd0);
    chk("ld.no_wb_yet", {31'd0, wb_valid}, 32'd0);
    tick();
    mem_rsp_valid = 1'b0;
    chk_wb("ld", 1'b1, 1'b1, 3'd2, 16'hBEEF);
    tick();
    chk("ld.one_rec", {31'd0, wb_valid}, 32'd0);
    chk("ld.ready_again", {31'd0, in_ready}, 32'd1);

    // 3: store with request stall
    in_valid = 1'b1;
    in_alusignals = OP_ST;
    in_aluresult = 16'h0041;
    in_stdata = 16'h00A5;
    in_rd = 3'd5;
    mem_req_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    in_aluresult = 16'h9999;
    in_stdata = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      chk("st.req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("st.req_we", {31'd0, mem_req_we}, 32'd1);
      chk("st.req_addr", {16'd0, mem_req_addr}, 32'h0041);
      chk("st.req_wdata", {16'd0, mem_req_wdata}, 32'h00A5);
      tick();
    end
    mem_req_ready = 1'b1;
    #1;
    chk("st.req_hold", {31'd0, mem_req_valid}, 32'd1);
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 16'h1234;
    tick();
    mem_rsp_valid = 1'b0;
    chk_wb("st", 1'b1, 1'b0, 3'd5, 16'h0000);
    tick();

    // 4: cmp then bubble under wb backpressure
    in_valid = 1'b1;
    in_alusignals = OP_CMP;
    in_aluresult = 16'h0077;
    in_rd = 3'd7;
    wb_ready = 1'b0;
    tick();
    chk_wb("cmp", 1'b1, 1'b0, 3'd7, 16'h0077);
    in_alusignals = 12'h000;
    in_aluresult = 16'h0055;
    in_rd = 3'd1;
    #1;
    chk("bub.blocked", {31'd0, in_ready}, 32'd0);
    tick();
    chk_wb("cmp.hold", 1'b1, 1'b0, 3'd7, 16'h0077);
    wb_ready = 1'b1;
    #1;
    chk("bub.ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk_wb("bub", 1'b1, 1'b0, 3'd1, 16'h0055);
    tick();
    chk("bub.drain", {31'd0, wb_valid}, 32'd0);

    // 5a: response on the expiry cycle wins
    in_valid = 1'b1;
    in_alusignals = OP_LD;
    in_aluresult = 16'h0050;
    in_rd = 3'd4;
    mem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    mem_req_ready = 1'b0;
    repeat (TO - 1) tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 16'hCAFE;
    tick();
    mem_rsp_valid = 1'b0;
    chk_wb("late_rsp", 1'b1, 1'b1, 3'd4, 16'hCAFE);
    chk("late_rsp.err", {31'd0, mem_err}, 32'd0);
    tick();

    // 5b: ld+st+add, ld wins, never answered
    in_valid = 1'b1;
    in_alusignals = OP_LD | OP_ST | OP_ADD;
    in_aluresult = 16'h1234;
    in_rd = 3'd6;
    mem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("to.req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("to.ld_wins", {31'd0, mem_req_we}, 32'd0);
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      chk("to.waiting", {31'd0, wb_valid}, 32'd0);
      chk("to.no_err", {31'd0, mem_err}, 32'd0);
      tick();
    end
    chk("to.last_wait", {31'd0, wb_valid}, 32'd0);
    tick();
    chk_wb("to", 1'b1, 1'b0, 3'd6, 16'h0000);
    chk("to.err", {31'd0, mem_err}, 32'd1);
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 16'hDEAD;
    tick();
    mem_rsp_valid = 1'b0;
    chk("stray.wb", {31'd0, wb_valid}, 32'd0);
    chk("stray.err", {31'd0, mem_err}, 32'd1);
    chk("stray.ready", {31'd0, in_ready}, 32'd1);

    // 6: async reset during MEM_WAIT
    in_valid = 1'b1;
    in_alusignals = OP_LD;
    in_aluresult = 16'h0060;
    in_rd = 3'd1;
    mem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    mem_req_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst.req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("arst.mem_err", {31'd0, mem_err}, 32'd0);
    chk_wb("arst", 1'b0, 1'b0, 3'd0, 16'h0000);
    tick();
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 16'h4321;
    tick();
    mem_rsp_valid = 1'b0;
    chk("arst.no_wb", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("arst.no_wb2", {31'd0, wb_valid}, 32'd0);
    chk("arst.idle", {31'd0, in_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
